// File: rtl/dma_local_responder.sv
// dma_local_responder: DMA read/write responder backed by an on-chip
// line RAM, with a backdoor port for preload and inspection.
module dma_local_responder #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int MEM_LINES  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [SIZE_WIDTH-1:0]        rd_size,
  input  logic                         rd_go,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         empty,
  output logic                         rd_done,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [SIZE_WIDTH-1:0]        wr_size,
  input  logic                         wr_go,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  output logic                         host_wr_completed,
  output logic                         wr_done,
  input  logic                         bd_we,
  input  logic                         bd_re,
  input  logic [$clog2(MEM_LINES)-1:0] bd_line,
  input  logic [DATA_WIDTH-1:0]        bd_wdata,
  output logic [DATA_WIDTH-1:0]        bd_rdata
);
  localparam int LW = $clog2(MEM_LINES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]           DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]           CNT1    = (PW+1)'(1);
  localparam logic [PW-1:0]         PTR1    = PW'(1);
  localparam logic [SIZE_WIDTH-1:0] ONE     = SIZE_WIDTH'(1);

  typedef enum logic {R_IDLE, R_ACTIVE} rd_st_t;
  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DRAIN} wr_st_t;

  logic [DATA_WIDTH-1:0] mem   [MEM_LINES];
  logic [DATA_WIDTH-1:0] rfifo [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wfifo [FIFO_DEPTH];

  rd_st_t                rd_st;
  logic [LW-1:0]         rd_base;
  logic [SIZE_WIDTH-1:0] rd_len, rd_iss, rd_pops;
  logic [PW-1:0]         r_wp, r_rp;
  logic [PW:0]           r_cnt;

  wr_st_t                wr_st;
  logic [LW-1:0]         wr_base;
  logic [SIZE_WIDTH-1:0] wr_len, wr_acc, wr_com;
  logic [PW-1:0]         w_wp, w_rp;
  logic [PW:0]           w_cnt;

  logic          rd_issue, rd_pop, wr_push, wr_drain;
  logic [LW-1:0] rd_line, wr_line;
  logic          unused_addr;

  assign unused_addr = ^{rd_addr[ADDR_WIDTH-1:6+LW], rd_addr[5:0],
                         wr_addr[ADDR_WIDTH-1:6+LW], wr_addr[5:0]};

  assign empty    = r_cnt == '0;
  assign rd_data  = empty ? '0 : rfifo[r_rp];
  assign rd_line  = rd_base + rd_iss[LW-1:0];
  // The RAM read lands directly in the FIFO slot, so nothing is in flight.
  assign rd_issue = rd_st == R_ACTIVE && !rd_go && !bd_re
                    && rd_iss != rd_len && r_cnt != DEPTH_C;
  assign rd_pop   = rd_en && !empty && !rd_go;

  assign full     = w_cnt == DEPTH_C || wr_st != W_ACCEPT;
  assign wr_line  = wr_base + wr_com[LW-1:0];
  assign wr_push  = wr_en && !full && !wr_go;
  assign wr_drain = w_cnt != '0 && !bd_we && !wr_go;

  always_ff @(posedge clk) begin
    if (bd_we)
      mem[bd_line] <= bd_wdata;
    else if (wr_drain)
      mem[wr_line] <= wfifo[w_rp];
  end

  always_ff @(posedge clk) begin
    if (rd_issue)
      rfifo[r_wp] <= mem[rd_line];
  end

  always_ff @(posedge clk) begin
    if (wr_push)
      wfifo[w_wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bd_rdata <= '0;
    else if (bd_re)
      bd_rdata <= mem[bd_line];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_st   <= R_IDLE;
      rd_base <= '0;
      rd_len  <= '0;
      rd_iss  <= '0;
      rd_pops <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      rd_done <= 1'b0;
    end else if (rd_go) begin
      rd_base <= rd_addr[6 +: LW];
      rd_len  <= rd_size;
      rd_iss  <= '0;
      rd_pops <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      rd_done <= rd_size == '0;
      rd_st   <= (rd_size == '0) ? R_IDLE : R_ACTIVE;
    end else begin
      if (rd_issue) begin
        r_wp   <= r_wp + PTR1;
        rd_iss <= rd_iss + ONE;
      end
      if (rd_pop) begin
        r_rp    <= r_rp + PTR1;
        rd_pops <= rd_pops + ONE;
        if (rd_pops + ONE == rd_len) begin
          rd_done <= 1'b1;
          rd_st   <= R_IDLE;
        end
      end
      unique case ({rd_issue, rd_pop})
        2'b10:   r_cnt <= r_cnt + CNT1;
        2'b01:   r_cnt <= r_cnt - CNT1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st             <= W_IDLE;
      wr_base           <= '0;
      wr_len            <= '0;
      wr_acc            <= '0;
      wr_com            <= '0;
      w_wp              <= '0;
      w_rp              <= '0;
      w_cnt             <= '0;
      host_wr_completed <= 1'b0;
      wr_done           <= 1'b0;
    end else if (wr_go) begin
      wr_base           <= wr_addr[6 +: LW];
      wr_len            <= wr_size;
      wr_acc            <= '0;
      wr_com            <= '0;
      w_wp              <= '0;
      w_rp              <= '0;
      w_cnt             <= '0;
      host_wr_completed <= wr_size == '0;
      wr_done           <= wr_size == '0;
      wr_st             <= (wr_size == '0) ? W_IDLE : W_ACCEPT;
    end else begin
      if (wr_push) begin
        w_wp   <= w_wp + PTR1;
        wr_acc <= wr_acc + ONE;
        if (wr_acc + ONE == wr_len) begin
          host_wr_completed <= 1'b1;
          wr_st             <= W_DRAIN;
        end
      end
      // Draining overlaps accepting so a deep transfer never deadlocks.
      if (wr_drain) begin
        w_rp   <= w_rp + PTR1;
        wr_com <= wr_com + ONE;
        if (wr_com + ONE == wr_len) begin
          wr_done <= 1'b1;
          wr_st   <= W_IDLE;
        end
      end
      unique case ({wr_push, wr_drain})
        2'b10:   w_cnt <= w_cnt + CNT1;
        2'b01:   w_cnt <= w_cnt - CNT1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_local_responder.sv
// tb_dma_local_responder: randomized bench with a transfer-level model
// of RAM contents, read streams and write acceptance.
module tb_dma_local_responder;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int SW = 43;
  localparam int ML = 1024;
  localparam int LW = 10;

  typedef logic [DW-1:0] line_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [SW-1:0] rd_size = '0;
  logic          rd_go = 1'b0;
  logic          rd_en = 1'b0;
  line_t         rd_data;
  logic          empty, rd_done;
  logic [AW-1:0] wr_addr = '0;
  logic [SW-1:0] wr_size = '0;
  logic          wr_go = 1'b0;
  logic          wr_en = 1'b0;
  line_t         wr_data = '0;
  logic          full, host_wr_completed, wr_done;
  logic          bd_we = 1'b0;
  logic          bd_re = 1'b0;
  logic [LW-1:0] bd_line = '0;
  line_t         bd_wdata = '0;
  line_t         bd_rdata;

  always #5 clk = ~clk;

  dma_local_responder dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_go(rd_go), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_addr(wr_addr), .wr_size(wr_size), .wr_go(wr_go), .wr_en(wr_en),
    .wr_data(wr_data), .full(full),
    .host_wr_completed(host_wr_completed), .wr_done(wr_done),
    .bd_we(bd_we), .bd_re(bd_re), .bd_line(bd_line),
    .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  line_t mm [ML];
  line_t exp_rd [$];
  int r_act = 0, r_size = 0, r_pops = 0;
  int w_act = 0, w_size = 0, w_acc = 0, w_base = 0;

  line_t p_q [$];
  int p_idx, p_n;

  task automatic chk(input string nm, input line_t act, input line_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic line_t rnd_line();
    line_t v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Compare against the model, then advance it by what the coming edge does.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_b("rst_empty", empty, 1'b1);
      chk_b("rst_full", full, 1'b1);
      chk_b("rst_rd_done", rd_done, 1'b0);
      chk_b("rst_wr_done", wr_done, 1'b0);
      chk_b("rst_hwc", host_wr_completed, 1'b0);
      chk("rst_rd_data", rd_data, '0);
      r_act = 0;
      w_act = 0;
      exp_rd.delete();
    end else begin
      if (!empty) begin
        if (r_act != 0 && r_pops < r_size)
          chk("rd_data", rd_data, exp_rd[r_pops]);
        else
          chk_b("rd_extra_line", empty, 1'b1);
      end
      chk_b("rd_done", rd_done, r_act != 0 && r_pops == r_size);
      if (r_act != 0 && r_pops == r_size)
        chk_b("rd_empty_after_done", empty, 1'b1);
      chk_b("hwc", host_wr_completed, w_act != 0 && w_acc == w_size);
      if (!(w_act != 0 && w_acc < w_size))
        chk_b("full_not_accepting", full, 1'b1);
      if (!(w_act != 0 && w_acc == w_size))
        chk_b("wr_done_early", wr_done, 1'b0);
      if (rd_go) begin
        int b;
        r_act = 1;
        r_size = int'(rd_size);
        r_pops = 0;
        exp_rd.delete();
        b = int'(rd_addr[6 +: LW]);
        for (int k = 0; k < r_size; k++) exp_rd.push_back(mm[(b + k) % ML]);
      end else if (rd_en && !empty) begin
        r_pops++;
      end
      if (wr_go) begin
        w_act = 1;
        w_size = int'(wr_size);
        w_acc = 0;
        w_base = int'(wr_addr[6 +: LW]);
      end else if (wr_en && !full) begin
        mm[(w_base + w_acc) % ML] = wr_data;
        w_acc++;
      end
      if (bd_we) mm[bd_line] = bd_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_read(input string nm, input int line, input line_t exp);
    bd_re = 1'b1;
    bd_line = LW'(line);
    cyc();
    bd_re = 1'b0;
    chk(nm, bd_rdata, exp);
  endtask

  task automatic push_step(input bit rnd);
    if (p_idx < p_n && !full && (!rnd || $urandom_range(0, 1) == 1)) begin
      wr_en = 1'b1;
      wr_data = p_q[p_idx];
      p_idx++;
    end else begin
      wr_en = 1'b0;
    end
  endtask

  task automatic read_run(input int line, input int n, input bit rnd,
                          output int cycles);
    rd_addr = AW'(line) << 6;
    rd_size = SW'(n);
    rd_go = 1'b1;
    cyc();
    rd_go = 1'b0;
    cycles = 1;
    while (!rd_done && cycles < 400) begin
      rd_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      cycles++;
    end
    rd_en = 1'b0;
    if (!rd_done) chk_b("rd_timeout", rd_done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    line_t a5;
    line_t old [4];
    line_t q [$];
    int wl [4];
    int cycles, t;
    a5 = {64{8'hA5}};
    wl = '{1022, 1023, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < ML; i++) begin
      bd_we = 1'b1;
      bd_line = LW'(i);
      bd_wdata = (i == 5) ? a5 : rnd_line();
      cyc();
    end
    bd_we = 1'b0;

    // Single-line loopback
    rd_addr = 64'h140;
    rd_size = SW'(1);
    rd_go = 1'b1;
    cyc();
    rd_go = 1'b0;
    chk_b("lb_empty_c1", empty, 1'b1);
    cyc();
    chk_b("lb_empty_c2", empty, 1'b0);
    chk("lb_data", rd_data, a5);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk_b("lb_rd_done", rd_done, 1'b1);
    wr_addr = 64'h180;
    wr_size = SW'(1);
    wr_go = 1'b1;
    cyc();
    wr_go = 1'b0;
    chk_b("lb_full_c1", full, 1'b0);
    wr_en = 1'b1;
    wr_data = a5;
    cyc();
    wr_en = 1'b0;
    chk_b("lb_hwc", host_wr_completed, 1'b1);
    chk_b("lb_wr_done_c1", wr_done, 1'b0);
    cyc();
    chk_b("lb_wr_done_c2", wr_done, 1'b1);
    bd_read("lb_bd_line6", 6, a5);

    // Streaming read, then the same range with random rd_en
    read_run(37, 16, 1'b0, cycles);
    chk_i("stream_cycles", cycles, 18);
    read_run(37, 16, 1'b1, cycles);

    // Write backpressure with the drain stalled by the backdoor
    p_q.delete();
    for (int k = 0; k < 8; k++) p_q.push_back(rnd_line());
    p_idx = 0;
    p_n = 8;
    bd_we = 1'b1;
    bd_line = LW'(900);
    bd_wdata = rnd_line();
    wr_addr = AW'(200) << 6;
    wr_size = SW'(8);
    wr_go = 1'b1;
    cyc();
    wr_go = 1'b0;
    repeat (10) begin
      push_step(1'b0);
      cyc();
    end
    wr_en = 1'b0;
    chk_i("bp_accepts", p_idx, 4);
    chk_b("bp_full", full, 1'b1);
    bd_we = 1'b0;
    t = 0;
    while (!wr_done && t < 100) begin
      push_step(1'b0);
      cyc();
      t++;
    end
    wr_en = 1'b0;
    chk_b("bp_wr_done", wr_done, 1'b1);
    for (int k = 0; k < 8; k++) bd_read("bp_line", 200 + k, p_q[k]);
    bd_read("bp_bd_line", 900, bd_wdata);

    // Wrap-around with junk in the ignored address bits
    rd_addr = 64'hABCD_0000_0000_0000 | (AW'(1022) << 6) | 64'h15;
    rd_size = SW'(4);
    rd_go = 1'b1;
    rd_en = 1'b1;
    cyc();
    rd_go = 1'b0;
    q.delete();
    t = 0;
    while (!rd_done && t < 50) begin
      if (!empty) q.push_back(rd_data);
      cyc();
      t++;
    end
    rd_en = 1'b0;
    chk_i("wrap_count", q.size(), 4);
    for (int k = 0; k < 4 && k < q.size(); k++) chk("wrap_line", q[k], mm[wl[k]]);

    // Zero sizes and ignored strobes
    rd_addr = '0;
    rd_size = '0;
    rd_go = 1'b1;
    cyc();
    rd_go = 1'b0;
    chk_b("zero_rd_done", rd_done, 1'b1);
    chk_b("zero_empty", empty, 1'b1);
    rd_en = 1'b1;
    repeat (3) cyc();
    rd_en = 1'b0;
    chk_b("ign_rd_done", rd_done, 1'b1);
    wr_addr = AW'(300) << 6;
    wr_size = '0;
    wr_go = 1'b1;
    cyc();
    wr_go = 1'b0;
    chk_b("zero_hwc", host_wr_completed, 1'b1);
    chk_b("zero_wr_done", wr_done, 1'b1);
    chk_b("zero_full", full, 1'b1);
    wr_en = 1'b1;
    wr_data = rnd_line();
    repeat (4) cyc();
    wr_en = 1'b0;
    repeat (3) cyc();
    bd_read("ign_wr_line", 300, mm[300]);

    // Reset mid-transfer: nothing accepted may reach the RAM
    for (int k = 0; k < 4; k++) old[k] = mm[400 + k];
    p_q.delete();
    for (int k = 0; k < 8; k++) p_q.push_back(rnd_line());
    p_idx = 0;
    p_n = 8;
    bd_we = 1'b1;
    bd_line = LW'(950);
    bd_wdata = rnd_line();
    wr_addr = AW'(400) << 6;
    wr_size = SW'(8);
    wr_go = 1'b1;
    rd_addr = AW'(10) << 6;
    rd_size = SW'(16);
    rd_go = 1'b1;
    cyc();
    wr_go = 1'b0;
    rd_go = 1'b0;
    rd_en = 1'b1;
    repeat (6) begin
      push_step(1'b0);
      cyc();
    end
    rst_n = 1'b0;
    bd_we = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    chk_b("mid_rst_empty", empty, 1'b1);
    chk_b("mid_rst_full", full, 1'b1);
    chk_b("mid_rst_hwc", host_wr_completed, 1'b0);
    chk("mid_rst_rd_data", rd_data, '0);
    cyc();
    for (int k = 0; k < 4; k++) mm[400 + k] = old[k];
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) bd_read("rst_no_commit", 400 + k, old[k]);

    // Restart mid-stream
    rd_addr = AW'(500) << 6;
    rd_size = SW'(16);
    rd_go = 1'b1;
    cyc();
    rd_go = 1'b0;
    rd_en = 1'b1;
    repeat (5) cyc();
    rd_addr = AW'(600) << 6;
    rd_size = SW'(8);
    rd_go = 1'b1;
    cyc();
    rd_go = 1'b0;
    cycles = 1;
    while (!rd_done && cycles < 100) begin
      cyc();
      cycles++;
    end
    rd_en = 1'b0;
    chk_i("restart_cycles", cycles, 10);

    // Concurrent random read and write on disjoint ranges
    for (int it = 0; it < 4; it++) begin
      int rb, wb;
      rb = $urandom_range(0, 400);
      wb = $urandom_range(600, 680);
      p_n = $urandom_range(1, 20);
      p_idx = 0;
      p_q.delete();
      for (int k = 0; k < p_n; k++) p_q.push_back(rnd_line());
      rd_addr = AW'(rb) << 6;
      rd_size = SW'($urandom_range(1, 20));
      wr_addr = AW'(wb) << 6;
      wr_size = SW'(p_n);
      rd_go = 1'b1;
      wr_go = 1'b1;
      cyc();
      rd_go = 1'b0;
      wr_go = 1'b0;
      t = 0;
      while (!(rd_done && wr_done) && t < 600) begin
        rd_en = 1'($urandom_range(0, 1));
        push_step(1'b1);
        cyc();
        t++;
      end
      rd_en = 1'b0;
      wr_en = 1'b0;
      chk_b("conc_rd_done", rd_done, 1'b1);
      chk_b("conc_wr_done", wr_done, 1'b1);
      for (int k = 0; k < p_n; k++) bd_read("conc_line", wb + k, p_q[k]);
    end

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
